regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 110 +++++++++++
 tb/tb_regfile_sb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard for a simple in-order pipeline.
// Register 0 is hard-wired to zero. An issue reserves a destination and a writeback
// releases it. Read ports report data plus a busy flag, and the stall output combines
// them. err is a sticky flag for issue/writeback protocol violations.
module regfile_sb #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = 32'h10010000,
  parameter bit               BYPASS      = 1'b1,
  localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              CW          = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    rs_num,
  input  logic [AW-1:0]    rt_num,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  output logic             rs_busy,
  output logic             rt_busy,
  input  logic             rs_use,
  input  logic             rt_use,
  output logic             stall,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_num,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_num,
  output logic [CW-1:0]    pend_count,
  output logic             err
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_act;
  logic             iss_act;
  logic             err_set;

  // Register 0 and numbers beyond DEPTH are inert.
  function automatic logic in_range(input logic [AW-1:0] n);
    return (n != '0) && (int'(n) < DEPTH);
  endfunction

  // Writes and issues are ignored while reset is held, so bypass stays quiet then as well.
  assign wr_act  = reset && wr_en && in_range(wr_num);
  assign iss_act = reset && iss_en && in_range(iss_num);

  // Next busy vector: writeback clears first, then issue sets, so a new reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_act) busy_nxt[wr_num] = 1'b0;
    if (iss_act) busy_nxt[iss_num] = 1'b1;
  end

  // Protocol error: double reservation, or a writeback with nothing outstanding.
  always_comb begin
    err_set = 1'b0;
    if (iss_act && busy[iss_num] && !(wr_act && (wr_num == iss_num))) err_set = 1'b1;
    if (wr_act && !busy[wr_num] && !(iss_act && (iss_num == wr_num))) err_set = 1'b1;
  end

  // Data array. Entry 0 is never written, so it stays at zero after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= (i == 0) ? '0 : RESET_VALUE;
    end else if (wr_act) begin
      regs[wr_num] <= wr_data;
    end
  end

  // Scoreboard state and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  // rs read port, with optional forwarding from the writeback port.
  always_comb begin
    rs_data = '0;
    rs_busy = 1'b0;
    if (BYPASS && wr_act && (rs_num == wr_num)) begin
      rs_data = wr_data;
    end else if (in_range(rs_num)) begin
      rs_data = regs[rs_num];
      rs_busy = busy[rs_num];
    end
  end

  // rt read port, with optional forwarding from the writeback port.
  always_comb begin
    rt_data = '0;
    rt_busy = 1'b0;
    if (BYPASS && wr_act && (rt_num == wr_num)) begin
      rt_data = wr_data;
    end else if (in_range(rt_num)) begin
      rt_data = regs[rt_num];
      rt_busy = busy[rt_num];
    end
  end

  assign stall      = (rs_use && rs_busy) || (rt_use && rt_busy);
  assign pend_count = CW'($countones(busy));

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb. Two instances share the same stimulus: one uses the
// default build, and the other uses DEPTH=24 with BYPASS=0, so out-of-range numbers are
// exercised as well. The driver pushes expected outputs from an array model, and a
// negedge monitor pops and compares them.
module tb_regfile_sb;

  localparam logic [31:0] RV = 32'h10010000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic [4:0]  rs_num = '0, rt_num = '0, wr_num = '0, iss_num = '0;
  logic        rs_use = 1'b0, rt_use = 1'b0, wr_en = 1'b0, iss_en = 1'b0;
  logic [31:0] wr_data = '0;

  logic [31:0] rs_data0, rt_data0, rs_data1, rt_data1;
  logic        rs_busy0, rt_busy0, stall0, err0;
  logic        rs_busy1, rt_busy1, stall1, err1;
  logic [5:0]  pend0;
  logic [4:0]  pend1;

  regfile_sb u_dut0 (
    .clock(clock), .reset(reset), .rs_num(rs_num), .rt_num(rt_num),
    .rs_data(rs_data0), .rt_data(rt_data0), .rs_busy(rs_busy0), .rt_busy(rt_busy0),
    .rs_use(rs_use), .rt_use(rt_use), .stall(stall0), .wr_en(wr_en), .wr_num(wr_num),
    .wr_data(wr_data), .iss_en(iss_en), .iss_num(iss_num), .pend_count(pend0), .err(err0)
  );

  regfile_sb #(.DEPTH(24), .BYPASS(1'b0)) u_dut1 (
    .clock(clock), .reset(reset), .rs_num(rs_num), .rt_num(rt_num),
    .rs_data(rs_data1), .rt_data(rt_data1), .rs_busy(rs_busy1), .rt_busy(rt_busy1),
    .rs_use(rs_use), .rt_use(rt_use), .stall(stall1), .wr_en(wr_en), .wr_num(wr_num),
    .wr_data(wr_data), .iss_en(iss_en), .iss_num(iss_num), .pend_count(pend1), .err(err1)
  );

  typedef struct {
    int          d;
    logic [31:0] rs_data, rt_data;
    logic        rs_busy, rt_busy, stall, err;
    int          pend;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model: plain arrays per instance.
  logic [31:0] mem [2][32];
  bit          bsy [2][32];
  bit          merr [2];

  function automatic int dep(int d);
    return (d == 0) ? 32 : 24;
  endfunction

  function automatic bit byp(int d);
    return d == 0;
  endfunction

  function automatic bit ok(int d, int n);
    return (n != 0) && (n < dep(d));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) begin
        mem[d][i] = (i == 0) ? 32'h0 : RV;
        bsy[d][i] = 1'b0;
      end
      merr[d] = 1'b0;
    end
  endtask

  task automatic model_read(input int d, input int n, output logic [31:0] data, output logic b);
    if (byp(d) && reset && wr_en && ok(d, int'(wr_num)) && n == int'(wr_num)) begin
      data = wr_data; b = 1'b0;
    end else if (ok(d, n)) begin
      data = mem[d][n]; b = bsy[d][n];
    end else begin
      data = 32'h0; b = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit wa, ia;
      wa = wr_en && ok(d, int'(wr_num));
      ia = iss_en && ok(d, int'(iss_num));
      if (ia && bsy[d][iss_num] && !(wa && wr_num == iss_num)) merr[d] = 1'b1;
      if (wa && !bsy[d][wr_num] && !(ia && iss_num == wr_num)) merr[d] = 1'b1;
      if (wa) begin
        mem[d][wr_num] = wr_data;
        bsy[d][wr_num] = 1'b0;
      end
      if (ia) bsy[d][iss_num] = 1'b1;
    end
  endtask

  task automatic push_exp();
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      int   c;
      e.d = d;
      model_read(d, int'(rs_num), e.rs_data, e.rs_busy);
      model_read(d, int'(rt_num), e.rt_data, e.rt_busy);
      e.stall = (rs_use && e.rs_busy) || (rt_use && e.rt_busy);
      e.err = merr[d];
      c = 0;
      for (int i = 0; i < 32; i++) if (bsy[d][i]) c++;
      e.pend = c;
      q.push_back(e);
    end
  endtask

  // One cycle: drive inputs shortly after the edge, queue expectations, then advance the model at the edge.
  task automatic step(input bit rst, input bit [4:0] rs, input bit [4:0] rt, input bit rsu,
                      input bit rtu, input bit we, input bit [4:0] wn, input bit [31:0] wd,
                      input bit ie, input bit [4:0] inum);
    reset = rst; rs_num = rs; rt_num = rt; rs_use = rsu; rt_use = rtu;
    wr_en = we; wr_num = wn; wr_data = wd; iss_en = ie; iss_num = inum;
    if (!rst) model_reset();
    push_exp();
    @(posedge clock);
    if (rst) model_edge();
    #1;
  endtask

  task automatic idle(input bit [4:0] rs, input bit [4:0] rt);
    step(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every queued expectation is compared at the next negedge.
  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.d == 0) begin
        cmp("rs_data", 0, rs_data0, e.rs_data);
        cmp("rt_data", 0, rt_data0, e.rt_data);
        cmp("rs_busy", 0, {31'b0, rs_busy0}, {31'b0, e.rs_busy});
        cmp("rt_busy", 0, {31'b0, rt_busy0}, {31'b0, e.rt_busy});
        cmp("stall", 0, {31'b0, stall0}, {31'b0, e.stall});
        cmp("err", 0, {31'b0, err0}, {31'b0, e.err});
        cmp("pend_count", 0, {26'b0, pend0}, e.pend);
      end else begin
        cmp("rs_data", 1, rs_data1, e.rs_data);
        cmp("rt_data", 1, rt_data1, e.rt_data);
        cmp("rs_busy", 1, {31'b0, rs_busy1}, {31'b0, e.rs_busy});
        cmp("rt_busy", 1, {31'b0, rt_busy1}, {31'b0, e.rt_busy});
        cmp("stall", 1, {31'b0, stall1}, {31'b0, e.stall});
        cmp("err", 1, {31'b0, err1}, {31'b0, e.err});
        cmp("pend_count", 1, {27'b0, pend1}, e.pend);
      end
    end
  end

  initial begin
    bit [4:0] wn, cand [$];
    model_reset();
    @(posedge clock); #1;

    // Reset, then release and read r0/r5.
    step(1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    idle(5'd0, 5'd5);

    // Issue r7, observe stall, then write back with forwarding.
    step(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    step(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    step(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
    idle(5'd7, 5'd0);

    // Same-cycle issue and writeback to r3.
    step(1'b1, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1234, 1'b1, 5'd3);
    idle(5'd3, 5'd0);

    // Double issue of r4 raises err; err holds, then a writeback to a non-busy r9 still updates it.
    step(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    step(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    for (int i = 0; i < 10; i++) idle(5'd4, 5'd9);
    step(1'b1, 5'd9, 5'd4, 1'b0, 1'b1, 1'b1, 5'd9, 32'hCAFE0009, 1'b0, 5'd0);
    idle(5'd9, 5'd4);

    // Reservations of r2..r4, then reset in mid-sequence.
    step(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
    step(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    step(1'b0, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd2, 32'h5, 1'b1, 5'd4);
    idle(5'd3, 5'd4);

    // Writeback r6=5 read on the same cycle; r0 and out-of-range activity.
    step(1'b1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
    step(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h5, 1'b0, 5'd0);
    idle(5'd6, 5'd0);
    step(1'b1, 5'd0, 5'd28, 1'b1, 1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0);
    step(1'b1, 5'd0, 5'd28, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd28);
    step(1'b1, 5'd28, 5'd0, 1'b1, 1'b1, 1'b1, 5'd28, 32'hABCD, 1'b0, 5'd0);
    idle(5'd28, 5'd0);

    // Random traffic. Writebacks mostly target busy registers, so err is not always set.
    for (int n = 0; n < 600; n++) begin
      cand.delete();
      for (int i = 1; i < 32; i++) if (bsy[0][i]) cand.push_back(5'(i));
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
        wn = cand[$urandom_range(0, cand.size() - 1)];
      else
        wn = 5'($urandom_range(0, 31));
      step($urandom_range(0, 59) != 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wn,
           $urandom, 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
